// File: rtl/station_pkg.sv
// Shared display codes and converter state encoding for the station temperature path.
package station_pkg;

  localparam logic [3:0] BCD_BLANK          = 4'hF;
  localparam logic [3:0] BCD_ERR_CODE       = 4'hA;
  localparam logic [7:0] DISP_BLANK_WORD    = {BCD_BLANK, BCD_BLANK};
  localparam logic [3:0] BCD_ADD3_THRESHOLD = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_FINISH  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/bcd_add3_adjust.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 so the next shift carries correctly.
module bcd_add3_adjust
  import station_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [3:0] o_nibble
);

  assign o_nibble = (i_nibble >= BCD_ADD3_THRESHOLD) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/temp_bcd_converter.sv
// Sequential binary-to-BCD converter (one double-dabble step per clock) feeding the
// seven-segment display with a blanked / error-coded two-digit temperature.
module temp_bcd_converter
  import station_pkg::*;
#(
  parameter int         IN_WIDTH           = 8,
  parameter bit         BLANK_LEADING_ZERO = 1'b1,
  parameter logic [7:0] OVR_CODE           = {BCD_ERR_CODE, BCD_ERR_CODE}
) (
  input  logic                sysCLK,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] binTemp,
  output logic [7:0]          decimalTemp,
  output logic                busy,
  output logic                done,
  output logic                overRange
);

  localparam int             CNT_W     = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_WIDTH - 1);

  // Three BCD digits hold at most 999, so inputs wider than 9 bits could overflow the hundreds digit.
  if (IN_WIDTH < 4 || IN_WIDTH > 9) begin : g_bad_width
    $error("temp_bcd_converter: IN_WIDTH must be within 4..9");
  end

  conv_state_t         r_state;
  conv_state_t         w_nextState;
  logic [IN_WIDTH-1:0] r_bin;
  logic [11:0]         r_bcd;
  logic [11:0]         w_bcdAdj;
  logic [CNT_W-1:0]    r_count;
  logic [7:0]          r_decimal;
  logic                r_busy;
  logic                r_done;
  logic                r_overRange;
  logic [7:0]          w_resultWord;
  logic                w_resultOvr;

  for (genvar g = 0; g < 3; g++) begin : g_adjust
    bcd_add3_adjust u_adjust (
      .i_nibble (r_bcd[4*g +: 4]),
      .o_nibble (w_bcdAdj[4*g +: 4])
    );
  end

  always_ff @(posedge sysCLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_nextState = ST_CONVERT;
      ST_CONVERT: if (r_count == LAST_ITER) w_nextState = ST_FINISH;
      ST_FINISH:  w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // Display formatting of the finished accumulator: error code, blanked tens, or plain digits.
  always_comb begin
    w_resultWord = r_bcd[7:0];
    w_resultOvr  = 1'b0;
    if (r_bcd[11:8] != 4'd0) begin
      w_resultWord = OVR_CODE;
      w_resultOvr  = 1'b1;
    end else if (BLANK_LEADING_ZERO && r_bcd[7:4] == 4'd0) begin
      w_resultWord = {BCD_BLANK, r_bcd[3:0]};
    end
  end

  always_ff @(posedge sysCLK) begin
    if (reset) begin
      r_bin       <= '0;
      r_bcd       <= '0;
      r_count     <= '0;
      r_decimal   <= DISP_BLANK_WORD;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overRange <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_bin   <= binTemp;
            r_bcd   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CONVERT: begin
          {r_bcd, r_bin} <= {w_bcdAdj, r_bin} << 1;
          r_count        <= r_count + CNT_W'(1);
        end
        ST_FINISH: begin
          r_decimal   <= w_resultWord;
          r_overRange <= w_resultOvr;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign decimalTemp = r_decimal;
  assign busy        = r_busy;
  assign done        = r_done;
  assign overRange   = r_overRange;

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Self-checking bench: randomized conversions against a decimal-arithmetic model, plus
// handshake, back-to-back and abort scenarios on blanking and non-blanking instances.
module tb_temp_bcd_converter;

  logic       sysCLK;
  logic       reset;
  logic       start;
  logic [7:0] binTemp;
  logic [7:0] decimalTemp, decimalTempNb;
  logic       busy, busyNb, done, doneNb, overRange, overRangeNb;

  int checks = 0;
  int fails  = 0;

  temp_bcd_converter #(.IN_WIDTH(8), .BLANK_LEADING_ZERO(1'b1)) dut (
    .sysCLK(sysCLK), .reset(reset), .start(start), .binTemp(binTemp),
    .decimalTemp(decimalTemp), .busy(busy), .done(done), .overRange(overRange)
  );

  temp_bcd_converter #(.IN_WIDTH(8), .BLANK_LEADING_ZERO(1'b0)) dutNoBlank (
    .sysCLK(sysCLK), .reset(reset), .start(start), .binTemp(binTemp),
    .decimalTemp(decimalTempNb), .busy(busyNb), .done(doneNb), .overRange(overRangeNb)
  );

  initial sysCLK = 1'b0;
  always #5 sysCLK = ~sysCLK;

  // Expected {overRange, decimalTemp} from plain decimal arithmetic.
  function automatic logic [8:0] model(input int v, input bit blank);
    int t, u;
    if (v > 99) return {1'b1, 8'hAA};
    t = v / 10;
    u = v % 10;
    if (t == 0 && blank) return {1'b0, 4'hF, u[3:0]};
    return {1'b0, t[3:0], u[3:0]};
  endfunction

  task automatic step();
    @(posedge sysCLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; binTemp = 8'd0;
    step(); step();
    checks++; if (decimalTemp !== 8'hFF) begin fails++; $display("[TB] FAIL reset_dec got=%h exp=ff", decimalTemp); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (overRange !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovr got=%b exp=0", overRange); end
    reset = 1'b0;
    step(); step(); step();
    checks++; if ({decimalTemp, busy, done} !== {8'hFF, 2'b00}) begin
      fails++; $display("[TB] FAIL reset_hold got dec=%h busy=%b done=%b exp ff/0/0", decimalTemp, busy, done);
    end
  endtask

  // One conversion with a 1-cycle start; binTemp is scrambled after capture.
  task automatic test_convert(input int value);
    logic [8:0] expB, expNb;
    logic [7:0] prevDec;
    int doneAt;
    bit busyBad, heldBad;
    expB  = model(value, 1'b1);
    expNb = model(value, 1'b0);
    binTemp = value[7:0]; start = 1'b1;
    step();
    start = 1'b0;
    prevDec = decimalTemp;
    doneAt = 0; busyBad = 1'b0; heldBad = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      binTemp = 8'($urandom);
      step();
      if (done) begin doneAt = n; break; end
      if (busy !== 1'b1) busyBad = 1'b1;
      if (decimalTemp !== prevDec) heldBad = 1'b1;
    end
    checks++; if (doneAt != 9) begin fails++; $display("[TB] FAIL conv_latency v=%0d got=%0d exp=9 (0=timeout)", value, doneAt); end
    checks++; if (busyBad) begin fails++; $display("[TB] FAIL conv_busy v=%0d got=dropped exp=held high", value); end
    checks++; if (heldBad) begin fails++; $display("[TB] FAIL conv_hold v=%0d got=changed exp=stable", value); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL conv_busy_end v=%0d got=%b exp=0", value, busy); end
    checks++; if ({overRange, decimalTemp} !== expB) begin
      fails++; $display("[TB] FAIL conv_blank v=%0d got=%b/%h exp=%b/%h", value, overRange, decimalTemp, expB[8], expB[7:0]);
    end
    checks++; if ({overRangeNb, decimalTempNb} !== expNb) begin
      fails++; $display("[TB] FAIL conv_noblank v=%0d got=%b/%h exp=%b/%h", value, overRangeNb, decimalTempNb, expNb[8], expNb[7:0]);
    end
    step();
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL conv_done_pulse v=%0d got=%b exp=0", value, done); end
  endtask

  task automatic test_boundaries();
    int vals[8] = '{72, 7, 0, 10, 9, 99, 100, 255};
    foreach (vals[i]) test_convert(vals[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) test_convert(int'($urandom_range(0, 255)));
  endtask

  task automatic test_start_while_busy();
    int dones, firstDone;
    binTemp = 8'd25; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    binTemp = 8'd60; start = 1'b1;
    step();
    start = 1'b0;
    dones = 0; firstDone = 0;
    for (int n = 4; n <= 24; n++) begin
      step();
      if (done) begin dones++; if (firstDone == 0) firstDone = n; end
    end
    checks++; if (dones != 1) begin fails++; $display("[TB] FAIL busy_start_dones got=%0d exp=1", dones); end
    checks++; if (firstDone != 9) begin fails++; $display("[TB] FAIL busy_start_latency got=%0d exp=9", firstDone); end
    checks++; if (decimalTemp !== 8'h25) begin fails++; $display("[TB] FAIL busy_start_result got=%h exp=25", decimalTemp); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    int lastDone, dones, v;
    bit seen;
    v = int'($urandom_range(0, 255));
    exp = model(v, 1'b1);
    binTemp = v[7:0]; start = 1'b1;
    lastDone = 0; dones = 0;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (done) begin
        checks++; if ({overRange, decimalTemp} !== exp) begin
          fails++; $display("[TB] FAIL b2b_result v=%0d got=%b/%h exp=%b/%h", v, overRange, decimalTemp, exp[8], exp[7:0]);
        end
        checks++; if (n - lastDone != 10) begin fails++; $display("[TB] FAIL b2b_interval got=%0d exp=10", n - lastDone); end
        lastDone = n; dones++;
        v = int'($urandom_range(0, 255));
        exp = model(v, 1'b1);
        binTemp = v[7:0];
      end
    end
    start = 1'b0;
    checks++; if (dones != 4) begin fails++; $display("[TB] FAIL b2b_count got=%0d exp=4", dones); end
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      seen = done;
    end
    checks++; if (!seen) begin fails++; $display("[TB] FAIL b2b_drain got=timeout exp=done"); end
    step();
  endtask

  task automatic test_abort();
    int dones;
    binTemp = 8'd88; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (decimalTemp !== 8'hFF) begin fails++; $display("[TB] FAIL abort_dec got=%h exp=ff", decimalTemp); end
    checks++; if ({busy, done, overRange} !== 3'b000) begin
      fails++; $display("[TB] FAIL abort_flags got=%b%b%b exp=000", busy, done, overRange);
    end
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done) dones++;
    end
    checks++; if (dones != 0 || decimalTemp !== 8'hFF) begin
      fails++; $display("[TB] FAIL abort_quiet got dones=%0d dec=%h exp 0/ff", dones, decimalTemp);
    end
    test_convert(31);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; binTemp = 8'd0;
    test_reset();
    test_boundaries();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_convert(50);
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/temp_bcd_converter.md
Name: temp_bcd_converter

Overview:
- Sequential binary-to-BCD converter for the station system's temperature path.
- Sits upstream of the seven-segment display driver and produces the 8-bit two-digit BCD temperature bus (decimalTemp) that the display consumes.
- Converts an unsigned binary temperature with shift-add-3 (double-dabble), one iteration per clock, under a start/busy/done handshake.
- Applies the display's blank code (4'hF) for leading-zero suppression and its error code for out-of-range values.

Parameters:
- IN_WIDTH, 8, width of binary input; legal range 4..9, so the maximum value (511) fits three BCD digits internally.
- BLANK_LEADING_ZERO, 1, when 1 the tens digit is driven 4'hF for values 0..9.
- OVR_CODE, 8'hAA, value driven on decimalTemp when the input exceeds 99; both nibbles are display error code 10.

Ports:
- sysCLK  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- binTemp  input  IN_WIDTH  unsigned binary temperature; captured on the accepted start edge.
- decimalTemp  output  8  [7:4] tens BCD, [3:0] units BCD; registered, held between conversions.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when decimalTemp and overRange update.
- overRange  output  1  registered, updates with decimalTemp; 1 when the captured value is greater than 99.

Behaviour:
- All state is updated on posedge sysCLK.
- Reset: state=IDLE, decimalTemp=8'hFF (both digits blank), busy=0, done=0, overRange=0, iteration counter=0, shift register cleared.
- Reset mid-conversion aborts immediately to the reset values. A partial result is never published.
- States:
  - IDLE:
    - start=1 at edge k: capture binTemp into the shift register, clear the 12-bit BCD accumulator, counter=0, go to CONVERT.
    - busy=1 from cycle k+1.
    - start=0: remain in IDLE.
  - CONVERT:
    - Each edge: every BCD nibble >=5 gets +3, then the combined {bcd, bin} register shifts left by one and counter increments.
    - After IN_WIDTH iterations (edges k+1..k+IN_WIDTH), go to FINISH.
  - FINISH:
    - At edge k+IN_WIDTH+1, load the output registers, set done=1 for exactly one cycle, set busy=0, go to IDLE.
- Latency: start accepted at edge k gives done high during the cycle after edge k+IN_WIDTH+1. Default: 9 edges.
- Output formatting at FINISH (hundreds H, tens T, units U):
  - H!=0 → decimalTemp=OVR_CODE, overRange=1.
  - Else T==0 and BLANK_LEADING_ZERO=1 → decimalTemp={4'hF,U}, overRange=0.
  - Else → decimalTemp={T,U}, overRange=0.
- Simultaneous events:
  - start while busy (CONVERT/FINISH) is ignored. No queuing, no error.
  - start high in the cycle done is asserted (state already IDLE) is accepted. Start held high therefore yields back-to-back conversions every IN_WIDTH+2 cycles.
  - Changes on binTemp after the capture edge do not affect the result.
  - reset takes priority over start.
- decimalTemp never shows an intermediate value; it changes only at FINISH or reset.
- Arithmetic: add-3 is applied per 4-bit nibble with no carry between nibbles. The accumulator is 12 bits; a width check guarantees no overflow of the hundreds nibble for IN_WIDTH<=9.

Decomposition:
- Shared package (station_pkg): BCD_BLANK=4'hF, BCD_ERR_CODE=4'hA, state encoding IDLE/CONVERT/FINISH (2-bit), display blank word 8'hFF.
- One natural sub-module: bcd_add3_adjust.
  - Combinational 4-bit nibble correction (in>=5 → in+3).
  - Instantiated three times inside CONVERT.
- Counter width: clog2(IN_WIDTH+1).

Test Plan:
- Assert reset for 2 cycles → decimalTemp=8'hFF, busy=0, done=0, overRange=0; release with start=0 → outputs hold.
- binTemp=72, 1-cycle start → busy=1 for the next 9 cycles, done pulses once exactly 9 edges after acceptance, decimalTemp=8'h72, overRange=0.
- Leading zero and boundary:
  - binTemp=7 → 8'hF7.
  - binTemp=0 → 8'hF0.
  - binTemp=10 → 8'h10.
  - With BLANK_LEADING_ZERO=0, binTemp=7 → 8'h07.
- Range edge:
  - binTemp=99 → 8'h99, overRange=0.
  - binTemp=100 → 8'hAA, overRange=1.
  - binTemp=255 → 8'hAA, overRange=1.
- Handshake:
  - start with binTemp=25, then binTemp=60 plus a second start pulse at iteration 3 → result 8'h25, single done, second start ignored.
  - start held high → done every 10 cycles.
- Abort: start with binTemp=88, assert reset at iteration 4 → next cycle decimalTemp=8'hFF, busy=0, no done pulse; a new start with 31 → 8'h31.
